// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM plus one LED register, with
// programmable wait states signalled on DataWaitreq.
module data_mem_responder #(
  parameter int unsigned           WORD_SIZE     = 16,
  parameter int unsigned           DEPTH         = 256,
  parameter int unsigned           READ_LATENCY  = 2,
  parameter int unsigned           WRITE_LATENCY = 1,
  parameter logic [WORD_SIZE-1:0]  LED_ADDR      = 16'h1000
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic [WORD_SIZE-1:0] LEDR,
  output logic                 Err
);

  localparam int unsigned          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(DEPTH);
  localparam logic [3:0]           RLAT    = 4'(READ_LATENCY);
  localparam logic [3:0]           WLAT    = 4'(WRITE_LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [WORD_SIZE-1:0] led_q, led_d;
  logic                 err_q, err_d;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // Requests are masked while reset is held so nothing can commit or
  // drive DataIn through the zero-latency path during reset.
  logic                 rd_g, wr_g, req;
  logic [3:0]           lat;
  logic                 cur_ram, cur_led;
  logic [WORD_SIZE-1:0] cur_rdata;
  logic                 commit;
  logic [WORD_SIZE-1:0] c_addr, c_data;
  logic                 mem_we;

  assign rd_g    = ReadData & Resetn;
  assign wr_g    = WriteData & Resetn;
  assign req     = rd_g | wr_g;
  assign lat     = wr_g ? WLAT : RLAT;
  assign cur_ram = (DataAddr < DEPTH_W);
  assign cur_led = (DataAddr == LED_ADDR);

  // Read value of whatever the live address decodes to (0 when unmapped).
  always_comb begin
    cur_rdata = '0;
    if (cur_ram)      cur_rdata = mem[DataAddr[AW-1:0]];
    else if (cur_led) cur_rdata = led_q;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    commit      = 1'b0;
    c_addr      = addr_q;
    c_data      = wdata_q;
    DataIn      = '0;
    DataWaitreq = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if ((rd_g & wr_g) | ~(cur_ram | cur_led)) err_d = 1'b1;
          if (lat == 4'd0) begin
            if (wr_g) begin
              commit = 1'b1;
              c_addr = DataAddr;
              c_data = DataOut;
            end else begin
              DataIn = cur_rdata;
            end
          end else begin
            DataWaitreq = 1'b1;
            wr_d        = wr_g;
            addr_d      = DataAddr;
            wdata_d     = DataOut;
            rdata_d     = wr_g ? '0 : cur_rdata;
            cnt_d       = lat - 4'd1;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          // Processor abandoned the access: drop it without committing.
          err_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          DataWaitreq = 1'b1;
          cnt_d       = cnt_q - 4'd1;
        end else begin
          if (wr_q) commit = 1'b1;
          else      DataIn = rdata_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route a committing write to RAM or LED; unmapped writes fall away.
  always_comb begin
    led_d  = led_q;
    mem_we = 1'b0;
    if (commit) begin
      if (c_addr < DEPTH_W)        mem_we = 1'b1;
      else if (c_addr == LED_ADDR) led_d  = c_data;
    end
  end

  // Control and latched-request registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      led_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[c_addr[AW-1:0]] <= c_data;
  end

  assign LEDR = led_q;
  assign Err  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances with different latencies,
// directed scenarios plus a random mix checked against a memory model.
module tb_data_mem_responder;

  localparam int          ND      = 3;
  localparam int          RLS [ND] = '{2, 0, 3};
  localparam int          WLS [ND] = '{1, 0, 2};
  localparam logic [15:0] LED     = 16'h1000;

  logic        clk;
  logic        Resetn;
  logic [15:0] addr_i, dout_i;
  logic        rd [ND];
  logic        wr [ND];
  logic [15:0] din [ND];
  logic        wt  [ND];
  logic [15:0] led [ND];
  logic        err [ND];

  int total = 0;
  int bad   = 0;

  logic [15:0] mmem [ND][256];
  bit          mval [ND][256];
  logic [15:0] mled [ND];
  bit          merr [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    data_mem_responder #(
      .WORD_SIZE(16), .DEPTH(256),
      .READ_LATENCY(RLS[g]), .WRITE_LATENCY(WLS[g]), .LED_ADDR(LED)
    ) u_dut (
      .Clock(clk), .Resetn(Resetn), .DataAddr(addr_i), .DataOut(dout_i),
      .ReadData(rd[g]), .WriteData(wr[g]), .DataIn(din[g]),
      .DataWaitreq(wt[g]), .LEDR(led[g]), .Err(err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one access: returns the read value and updates
  // the architectural state (RAM, LED, sticky error).
  function automatic logic [15:0] model_op(int d, bit w, bit r, logic [15:0] a, logic [15:0] wd);
    logic [15:0] res;
    res = 16'h0;
    if (w && r) merr[d] = 1'b1;
    if (a < 16'd256) begin
      if (w) begin mmem[d][a[7:0]] = wd; mval[d][a[7:0]] = 1'b1; end
      else res = mmem[d][a[7:0]];
    end else if (a == LED) begin
      if (w) mled[d] = wd; else res = mled[d];
    end else begin
      merr[d] = 1'b1;
    end
    return res;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin mled[d] = 16'h0; merr[d] = 1'b0; end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one access on instance d and hold it until DataWaitreq drops.
  // With chg set, address and data are scrambled once the access is in flight.
  task automatic access(input int d, input bit w, input bit r, input logic [15:0] a,
                        input logic [15:0] wd, input bit chg,
                        output logic [15:0] rdata, output int waits);
    bit done;
    done = 1'b0; waits = 0; rdata = 16'hxxxx;
    rd[d] = r; wr[d] = w; addr_i = a; dout_i = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (wt[d] === 1'b0) begin done = 1'b1; rdata = din[d]; end
      else waits++;
      @(posedge clk); #1;
      if (chg) begin addr_i = ~a; dout_i = ~wd; end
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout dut%0d addr=%h: DataWaitreq never dropped", d, a);
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    tick(2);
    for (int d = 0; d < ND; d++) begin
      total++;
      if (wt[d] !== 1'b0 || din[d] !== 16'h0 || led[d] !== 16'h0 || err[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d: wait=%b din=%h led=%h err=%b, want 0/0/0/0",
                 d, wt[d], din[d], led[d], err[d]);
      end
    end
    Resetn = 1'b1;
    model_reset();
    tick(1);
  endtask

  task automatic test_basic();
    logic [15:0] rv, ex; int w;
    ex = model_op(0, 1, 0, 16'd5, 16'h00AB);
    access(0, 1, 0, 16'd5, 16'h00AB, 1'b0, rv, w);
    total++; if (w !== 1) begin bad++; $display("FAIL basic_wr_wait: got %0d want 1", w); end
    ex = model_op(0, 0, 1, 16'd5, 16'h0);
    access(0, 0, 1, 16'd5, 16'h0, 1'b0, rv, w);
    total++; if (w !== 2) begin bad++; $display("FAIL basic_rd_wait: got %0d want 2", w); end
    total++; if (rv !== ex) begin bad++; $display("FAIL basic_rd_data: got %h want %h", rv, ex); end
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err[0]); end
  endtask

  task automatic test_zero_lat();
    logic [15:0] rv, ex; int w1, w2;
    ex = model_op(1, 1, 0, 16'd7, 16'h1234);
    access(1, 1, 0, 16'd7, 16'h1234, 1'b0, rv, w1);
    ex = model_op(1, 0, 1, 16'd7, 16'h0);
    access(1, 0, 1, 16'd7, 16'h0, 1'b0, rv, w2);
    total++; if (w1 + w2 !== 0) begin bad++; $display("FAIL zlat_wait: got %0d/%0d want 0/0", w1, w2); end
    total++; if (rv !== ex) begin bad++; $display("FAIL zlat_data: got %h want %h", rv, ex); end
  endtask

  task automatic test_led();
    logic [15:0] rv, ex; int w;
    ex = model_op(0, 1, 0, LED, 16'h03FF);
    access(0, 1, 0, LED, 16'h03FF, 1'b0, rv, w);
    total++; if (led[0] !== mled[0]) begin bad++; $display("FAIL led_reg: got %h want %h", led[0], mled[0]); end
    ex = model_op(0, 0, 1, LED, 16'h0);
    access(0, 0, 1, LED, 16'h0, 1'b0, rv, w);
    total++; if (rv !== ex) begin bad++; $display("FAIL led_read: got %h want %h", rv, ex); end
  endtask

  task automatic test_unmapped();
    logic [15:0] rv, ex; int w;
    ex = model_op(0, 1, 0, 16'd0, 16'h4242);
    access(0, 1, 0, 16'd0, 16'h4242, 1'b0, rv, w);
    ex = model_op(0, 0, 1, 16'h0800, 16'h0);
    access(0, 0, 1, 16'h0800, 16'h0, 1'b0, rv, w);
    total++; if (w !== 2 || rv !== ex) begin bad++; $display("FAIL unm_read: wait=%0d data=%h want 2/%h", w, rv, ex); end
    total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL unm_err: got %b want 1", err[0]); end
    tick(3);
    total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL unm_err_sticky: got %b want 1", err[0]); end
    ex = model_op(0, 1, 0, 16'h0800, 16'h9999);
    access(0, 1, 0, 16'h0800, 16'h9999, 1'b0, rv, w);
    total++; if (w !== 1) begin bad++; $display("FAIL unm_wr_wait: got %0d want 1", w); end
    ex = model_op(0, 0, 1, 16'd0, 16'h0);
    access(0, 0, 1, 16'd0, 16'h0, 1'b0, rv, w);
    total++; if (rv !== ex) begin bad++; $display("FAIL unm_alias: mem[0] got %h want %h", rv, ex); end
  endtask

  task automatic test_abort();
    logic [15:0] rv, ex; int w;
    ex = model_op(2, 1, 0, 16'd9, 16'h1111);
    access(2, 1, 0, 16'd9, 16'h1111, 1'b0, rv, w);
    total++; if (w !== 2) begin bad++; $display("FAIL abort_pre_wait: got %0d want 2", w); end
    ex = model_op(2, 1, 0, LED, 16'h00C3);
    access(2, 1, 0, LED, 16'h00C3, 1'b0, rv, w);
    total++; if (err[2] !== merr[2]) begin bad++; $display("FAIL abort_pre_err: got %b want %b", err[2], merr[2]); end
    wr[2] = 1'b1; addr_i = 16'd9; dout_i = 16'h2222;
    tick(1);
    wr[2] = 1'b0;
    tick(1);
    merr[2] = 1'b1;
    total++; if (wt[2] !== 1'b0 || err[2] !== 1'b1) begin
      bad++; $display("FAIL abort_state: wait=%b err=%b want 0/1", wt[2], err[2]);
    end
    ex = model_op(2, 0, 1, 16'd9, 16'h0);
    access(2, 0, 1, 16'd9, 16'h0, 1'b0, rv, w);
    total++; if (w !== 3 || rv !== ex) begin bad++; $display("FAIL abort_nocommit: wait=%0d data=%h want 3/%h", w, rv, ex); end
  endtask

  task automatic test_reset_midread();
    rd[2] = 1'b1; addr_i = 16'd9;
    tick(1);
    #2 Resetn = 1'b0;
    #1;
    total++; if (wt[2] !== 1'b0 || din[2] !== 16'h0 || led[2] !== 16'h0 || err[2] !== 1'b0) begin
      bad++; $display("FAIL rst_mid: wait=%b din=%h led=%h err=%b want 0/0/0/0", wt[2], din[2], led[2], err[2]);
    end
    total++; if (led[0] !== 16'h0) begin bad++; $display("FAIL rst_mid_led0: got %h want 0", led[0]); end
    rd[2] = 1'b0;
    tick(1);
    Resetn = 1'b1;
    model_reset();
    tick(1);
  endtask

  task automatic test_both_high();
    logic [15:0] rv, ex; int w;
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL both_pre_err: got %b want 0", err[0]); end
    ex = model_op(0, 1, 1, 16'd3, 16'h0055);
    access(0, 1, 1, 16'd3, 16'h0055, 1'b0, rv, w);
    total++; if (w !== 1 || err[0] !== 1'b1) begin bad++; $display("FAIL both_wr: wait=%0d err=%b want 1/1", w, err[0]); end
    ex = model_op(0, 0, 1, 16'd3, 16'h0);
    access(0, 0, 1, 16'd3, 16'h0, 1'b0, rv, w);
    total++; if (rv !== ex) begin bad++; $display("FAIL both_data: got %h want %h", rv, ex); end
  endtask

  task automatic test_addr_change();
    logic [15:0] rv, ex; int w;
    ex = model_op(0, 1, 0, 16'd10, 16'h7777);
    access(0, 1, 0, 16'd10, 16'h7777, 1'b1, rv, w);
    ex = model_op(0, 0, 1, 16'd10, 16'h0);
    access(0, 0, 1, 16'd10, 16'h0, 1'b1, rv, w);
    total++; if (w !== 2 || rv !== ex) begin bad++; $display("FAIL addr_change: wait=%0d data=%h want 2/%h", w, rv, ex); end
  endtask

  task automatic test_random();
    logic [15:0] rv, ex, a, wd; int w, pick; bit isw, isr;
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 50; n++) begin
        pick = $urandom_range(0, 19);
        wd   = 16'($urandom);
        if (pick < 14)      a = 16'($urandom_range(0, 15));
        else if (pick < 17) a = LED;
        else                a = 16'h0800 + 16'($urandom_range(0, 15));
        isw = $urandom_range(0, 1) == 1;
        if (!isw && a < 16'd256 && !mval[d][a[7:0]]) isw = 1'b1;
        isr = !isw || ($urandom_range(0, 15) == 0);
        ex = model_op(d, isw, isr, a, wd);
        access(d, isw, isr, a, wd, 1'b0, rv, w);
        total++;
        if (w !== (isw ? WLS[d] : RLS[d])) begin
          bad++; $display("FAIL rnd_wait dut%0d op%0d: got %0d want %0d", d, n, w, isw ? WLS[d] : RLS[d]);
        end
        if (!isw) begin
          total++;
          if (rv !== ex) begin bad++; $display("FAIL rnd_data dut%0d op%0d addr=%h: got %h want %h", d, n, a, rv, ex); end
        end
      end
      total++;
      if (err[d] !== merr[d] || led[d] !== mled[d]) begin
        bad++; $display("FAIL rnd_final dut%0d: err=%b led=%h want %b/%h", d, err[d], led[d], merr[d], mled[d]);
      end
    end
  endtask

  initial begin
    Resetn = 1'b0; addr_i = '0; dout_i = '0;
    for (int d = 0; d < ND; d++) begin rd[d] = 1'b0; wr[d] = 1'b0; end
    for (int d = 0; d < ND; d++) for (int i = 0; i < 256; i++) begin
      mmem[d][i] = 16'h0; mval[d][i] = 1'b0;
    end
    model_reset();
    test_reset();
    test_basic();
    test_zero_lat();
    test_led();
    test_unmapped();
    test_abort();
    test_reset_midread();
    test_both_high();
    test_addr_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side memory responder for the 5-stage pipelined processor: sits on the far end of the processor's data port (DataAddr/DataOut/ReadData/WriteData in, DataIn/DataWaitreq out). It services loads and stores from an internal word-addressed RAM plus one memory-mapped LED register. It inserts a programmable number of wait states by holding DataWaitreq high, which is what stalls the processor's Memory stage and everything behind it.

## Interface

- WORD_SIZE, 16, data and address width
- DEPTH, 256, RAM words; power of two, at most 2**(WORD_SIZE-1)
- READ_LATENCY, 2, wait cycles per read, 0..15
- WRITE_LATENCY, 1, wait cycles per write, 0..15
- LED_ADDR, 16'h1000, address of the LED register; must be >= DEPTH

- Clock  in  1  single clock; all state on rising edge
- Resetn  in  1  asynchronous, active-low reset
- DataAddr  in  WORD_SIZE  word address from processor
- DataOut  in  WORD_SIZE  store data from processor
- ReadData  in  1  load request
- WriteData  in  1  store request
- DataIn  out  WORD_SIZE  load data to processor; 0 when no read completes
- DataWaitreq  out  1  1 = request not yet complete, processor must hold
- LEDR  out  WORD_SIZE  LED register contents
- Err  out  1  sticky protocol/address error flag

## Operation

- Decode: addr < DEPTH -> RAM; addr == LED_ADDR -> LEDR; anything else is unmapped.
- Request = ReadData | WriteData. If both are high, the write wins and Err is set.
- Latency L = WRITE_LATENCY for writes, otherwise READ_LATENCY.
- FSM states: IDLE, BUSY (4-bit down-counter cnt).
- IDLE, no request: DataWaitreq=0, DataIn=0.
- IDLE, request, L=0:
  - Completes in the same cycle with DataWaitreq=0.
  - Read: DataIn = mem[addr] combinationally.
  - Write: committed at this edge.
  - Stay in IDLE.
- IDLE, request, L>0:
  - DataWaitreq=1 combinationally in this cycle.
  - At the edge: latch kind, addr and write data; latch read data from the target; cnt<=L-1; go to BUSY.
- BUSY, cnt!=0: DataWaitreq=1; cnt decrements each edge.
- BUSY, cnt==0 (completion cycle):
  - DataWaitreq=0.
  - Read: DataIn = latched read data.
  - Write: committed at the edge.
  - Go to IDLE at the edge.
- The address and write data latched at accept are authoritative. Changes on DataAddr/DataOut during BUSY are ignored.
- Request dropped during BUSY (ReadData and WriteData both 0): abort, go to IDLE next edge, no commit, set Err.
- Unmapped access: completes with normal timing, reads return 0, writes are discarded, Err is set.
- Err is set on the edge where its condition is seen and is cleared only by reset.

## Timing

- Reset (async assert, any state):
  - state=IDLE, cnt=0, LEDR=0, Err=0, latched regs=0.
  - DataWaitreq=0 and DataIn=0 immediately.
  - RAM contents are not cleared.
  - An access in flight is dropped with no commit.
- Access occupancy:
  - L>0: L+1 cycles (L wait cycles plus one completion cycle); next request accepted the cycle after completion.
  - L=0: one access per cycle, back-to-back.
- Example, READ_LATENCY=2, request in cycle 0: DataWaitreq=1 in cycles 0 and 1; DataWaitreq=0 with DataIn valid in cycle 2; IDLE in cycle 3.
- A write committed at edge E is visible to a read accepted at or after edge E.
- Read-after-write: a read issued in the cycle after a write's completion returns the new value.
- DataIn and DataWaitreq are functions of state and current inputs only (no registered-output delay). The processor samples both in the same cycle.

## Test plan

- Reset, then write 16'h00AB to addr 5 (WRITE_LATENCY=1) -> DataWaitreq high 1 cycle, low on the 2nd cycle. Read addr 5 (READ_LATENCY=2) -> DataWaitreq high 2 cycles, DataIn=16'h00AB on the 3rd cycle, Err=0.
- Latencies 0/0: back-to-back write 16'h1234 to addr 7, then read addr 7 in the next cycle -> DataWaitreq never high, DataIn=16'h1234 same cycle.
- Write 16'h03FF to LED_ADDR -> LEDR=16'h03FF after the completion edge. Read LED_ADDR -> DataIn=16'h03FF.
- Read addr 16'h0800 (unmapped) -> normal wait timing, DataIn=0, Err=1 and stays 1. Write there -> no RAM word changes.
- Write issued, WriteData dropped in cycle 1 of a 3-cycle write -> return to IDLE, target word unchanged, Err=1. Also assert Resetn low mid-read -> outputs 0 immediately, LEDR=0, Err=0.
- ReadData and WriteData both high with addr 3, data 16'h0055 -> treated as a write (mem[3]=16'h0055), Err=1. Also change DataAddr during BUSY -> original address is used.
